seq_det_scan_ctrl: RTL

- Word-level controller for a single-bit serial Mealy sequence detector (1011 pattern, registered input, one-cycle match latency).
- Accepts parallel words over a valid/ready handshake and serializes each word MSB-first into the detector.
- Optionally clears the detector before a word, then attributes each detector match pulse to a bit index.
- Returns a per-word result (match count, first match position) over a second valid/ready handshake, and keeps a running saturating total.

---
 rtl/seq_det_scan_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seq_det_scan_ctrl.sv
// Word-level controller for a serial 1011 Mealy detector: serializes words MSB-first,
// attributes detector matches to bit indices and reports per-word results.
module seq_det_scan_ctrl #(
  parameter int W       = 16,
  parameter int DET_LAT = 1,
  parameter int CNT_W   = $clog2(W + 1),
  parameter int POS_W   = $clog2(W),
  parameter int TOT_W   = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  input  logic             s_restart,
  output logic             det_bit,
  output logic             det_rst,
  input  logic             det_match,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [CNT_W-1:0] r_count,
  output logic             r_hit,
  output logic [POS_W-1:0] r_first_pos,
  output logic [TOT_W-1:0] total_matches,
  output logic             busy
);

  localparam int DC_W = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    SHIFT  = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [W-1:0]       buf_r;
  logic [W-1:0]       buf_nxt_s;
  logic [POS_W-1:0]   shift_cnt_r;
  logic [DC_W-1:0]    drain_cnt_r;
  logic [DET_LAT-1:0] tag_v_r;
  logic [POS_W-1:0]   tag_idx_r [DET_LAT];
  logic               accept_s;
  logic               hit_now_s;

  assign accept_s  = (state_r == IDLE) && s_valid;
  assign hit_now_s = tag_v_r[DET_LAT-1] && det_match;

  // Next-state and next-buffer logic; the buffer shifts left so its MSB is the bit on the wire.
  always_comb begin
    state_nxt_s = state_r;
    buf_nxt_s   = buf_r;
    case (state_r)
      IDLE: begin
        if (s_valid) begin
          buf_nxt_s   = s_data;
          state_nxt_s = s_restart ? CLR : SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLR: state_nxt_s = SHIFT;
      SHIFT: begin
        buf_nxt_s = {buf_r[W-2:0], 1'b0};
        if (shift_cnt_r == POS_W'(W - 1)) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DRAIN: begin
        if (drain_cnt_r == DC_W'(DET_LAT - 1)) begin
          state_nxt_s = REPORT;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      REPORT: begin
        if (r_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REPORT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, buffer, cycle counters and registered control outputs decoded from the next state.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r     <= IDLE;
      buf_r       <= {W{1'b0}};
      shift_cnt_r <= {POS_W{1'b0}};
      drain_cnt_r <= {DC_W{1'b0}};
      s_ready     <= 1'b1;
      busy        <= 1'b0;
      r_valid     <= 1'b0;
      det_rst     <= 1'b0;
      det_bit     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      buf_r       <= buf_nxt_s;
      shift_cnt_r <= (state_r == SHIFT) ? shift_cnt_r + POS_W'(1) : {POS_W{1'b0}};
      drain_cnt_r <= (state_r == DRAIN) ? drain_cnt_r + DC_W'(1) : {DC_W{1'b0}};
      s_ready     <= (state_nxt_s == IDLE);
      busy        <= (state_nxt_s != IDLE);
      r_valid     <= (state_nxt_s == REPORT);
      det_rst     <= (state_nxt_s == CLR);
      det_bit     <= (state_nxt_s == SHIFT) && buf_nxt_s[W-1];
    end
  end

  // Tag pipeline: the tag reaching the last stage lines up with the detector's answer for that bit.
  always_ff @(posedge clock) begin
    if (rst) begin
      tag_v_r <= {DET_LAT{1'b0}};
      for (int i = 0; i < DET_LAT; i++) begin
        tag_idx_r[i] <= {POS_W{1'b0}};
      end
    end else begin
      tag_v_r[0]   <= (state_r == SHIFT);
      tag_idx_r[0] <= shift_cnt_r;
      for (int i = 1; i < DET_LAT; i++) begin
        tag_v_r[i]   <= tag_v_r[i-1];
        tag_idx_r[i] <= tag_idx_r[i-1];
      end
    end
  end

  // Per-word result fields and the saturating running total.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_count       <= {CNT_W{1'b0}};
      r_hit         <= 1'b0;
      r_first_pos   <= {POS_W{1'b0}};
      total_matches <= {TOT_W{1'b0}};
    end else begin
      if (accept_s) begin
        r_count     <= {CNT_W{1'b0}};
        r_hit       <= 1'b0;
        r_first_pos <= {POS_W{1'b0}};
      end else if (hit_now_s) begin
        r_count <= r_count + CNT_W'(1);
        if (!r_hit) begin
          r_hit       <= 1'b1;
          r_first_pos <= tag_idx_r[DET_LAT-1];
        end
      end
      if (hit_now_s && (total_matches != {TOT_W{1'b1}})) begin
        total_matches <= total_matches + TOT_W'(1);
      end
    end
  end

endmodule
